// File: rtl/tp_pkg.sv
// rtl/tp_pkg.sv - shared TEST_PATTERN timing defaults, state encoding and frame-start tail helper
package tp_pkg;

  localparam int H_TOTAL_DEF     = 910;
  localparam int V_TOTAL_DEF     = 262;
  localparam int CONFIRM_LNS_DEF = 4;
  localparam int UNLOCK_TH_DEF   = 8;
  localparam int ERR_W_DEF       = 16;
  localparam int H_W             = 10;
  localparam int V_W             = 9;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCK    = 2'd2
  } tp_state_e;

  // Low byte of the last counter value of a line/frame; the sample before frame start carries it.
  function automatic logic [7:0] fs_tail(input int total);
    return 8'((total - 1) % 256);
  endfunction

endpackage

// File: rtl/tp_expect_gen.sv
// rtl/tp_expect_gen.sv - recovered H/V/F counters and the expected RGB for the next sample
module tp_expect_gen
  import tp_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic           i_clk,
  input  logic           i_xar,
  input  logic           i_seed,
  input  logic [7:0]     i_seed_f,
  input  logic           i_adv,
  output logic [H_W-1:0] o_h,
  output logic [V_W-1:0] o_v,
  output logic           o_h_wrap,
  output logic           o_v_wrap,
  output logic [23:0]    o_exp
);

  logic [H_W-1:0] r_h;
  logic [V_W-1:0] r_v;
  logic [7:0]     r_f;
  logic [7:0]     w_g;

  assign o_h_wrap = (r_h == H_W'(H_TOTAL - 1));
  assign o_v_wrap = o_h_wrap && (r_v == V_W'(V_TOTAL - 1));
  assign w_g      = r_v[7:0] + r_f + r_h[7:0];
  assign o_exp    = {r_h[7:0], w_g, r_v[7:0]};
  assign o_h      = r_h;
  assign o_v      = r_v;

  // Seeding points at H=1: the frame-start sample itself has already been consumed.
  always_ff @(posedge i_clk) begin
    if (!i_xar) begin
      r_h <= '0;
      r_v <= '0;
      r_f <= '0;
    end else if (i_seed) begin
      r_h <= H_W'(1);
      r_v <= '0;
      r_f <= i_seed_f;
    end else if (i_adv) begin
      if (o_h_wrap) begin
        r_h <= '0;
        if (o_v_wrap) begin
          r_v <= '0;
          r_f <= r_f + 8'd1;
        end else begin
          r_v <= r_v + V_W'(1);
        end
      end else begin
        r_h <= r_h + H_W'(1);
      end
    end
  end

endmodule

// File: rtl/test_pattern_checker.sv
// rtl/test_pattern_checker.sv - TEST_PATTERN receive checker: frame-start search, lock FSM, error/frame counters
module test_pattern_checker
  import tp_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int CONFIRM_LNS = CONFIRM_LNS_DEF,
  parameter int UNLOCK_TH   = UNLOCK_TH_DEF,
  parameter int ERR_W       = ERR_W_DEF
) (
  input  logic             CK_i,
  input  logic             XAR_i,
  input  logic             CK_EE_i,
  input  logic [7:0]       R_i,
  input  logic [7:0]       G_i,
  input  logic [7:0]       B_i,
  input  logic             CLR_i,
  output logic             LOCK_o,
  output logic             ERR_o,
  output logic [ERR_W-1:0] ERRCTRs_o,
  output logic [7:0]       FRMCTRs_o,
  output logic [H_W-1:0]   HCTRs_o,
  output logic [V_W-1:0]   VCTRs_o
);

  localparam logic [7:0] FS_R = fs_tail(H_TOTAL);
  localparam logic [7:0] FS_B = fs_tail(V_TOTAL);

  tp_state_e        r_state, w_state_nxt;
  logic [7:0]       r_prev_r, r_prev_b;
  logic [7:0]       r_lines, r_cons;
  logic             r_err;
  logic [ERR_W-1:0] r_errctr;
  logic [7:0]       r_frmctr;
  logic             w_fs, w_miss, w_seed, w_adv, w_err_hit, w_lines_inc;
  logic             w_h_wrap, w_v_wrap;
  logic [23:0]      w_exp;

  tp_expect_gen #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_expect (
    .i_clk    (CK_i),
    .i_xar    (XAR_i),
    .i_seed   (w_seed),
    .i_seed_f (G_i),
    .i_adv    (w_adv),
    .o_h      (HCTRs_o),
    .o_v      (VCTRs_o),
    .o_h_wrap (w_h_wrap),
    .o_v_wrap (w_v_wrap),
    .o_exp    (w_exp)
  );

  assign w_fs   = (R_i == 8'd0) && (B_i == 8'd0) && (r_prev_r == FS_R) && (r_prev_b == FS_B);
  assign w_miss = ({R_i, G_i, B_i} != w_exp);

  always_comb begin
    w_state_nxt = r_state;
    w_seed      = 1'b0;
    w_adv       = 1'b0;
    w_err_hit   = 1'b0;
    w_lines_inc = 1'b0;
    if (CK_EE_i) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_fs) begin
            w_seed      = 1'b1;
            w_state_nxt = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          w_adv = 1'b1;
          if (w_miss) begin
            w_state_nxt = ST_SEARCH;
          end else if (w_h_wrap) begin
            w_lines_inc = 1'b1;
            if (r_lines == 8'(CONFIRM_LNS - 1)) w_state_nxt = ST_LOCK;
          end
        end
        ST_LOCK: begin
          w_adv = 1'b1;
          if (w_miss) begin
            w_err_hit = 1'b1;
            if (r_cons == 8'(UNLOCK_TH - 1)) w_state_nxt = ST_SEARCH;
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge CK_i) begin
    if (!XAR_i) begin
      r_state  <= ST_SEARCH;
      r_prev_r <= '0;
      r_prev_b <= '0;
      r_lines  <= '0;
      r_cons   <= '0;
      r_err    <= 1'b0;
      r_errctr <= '0;
      r_frmctr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_hit;
      if (CK_EE_i) begin
        r_prev_r <= R_i;
        r_prev_b <= B_i;
      end
      if (r_state != ST_CONFIRM) r_lines <= '0;
      else if (w_lines_inc)      r_lines <= r_lines + 8'd1;
      // Run length only matters while staying locked; any exit restarts it.
      if (w_state_nxt != ST_LOCK) r_cons <= '0;
      else if (CK_EE_i)           r_cons <= w_miss ? r_cons + 8'd1 : 8'd0;
      if (CLR_i)                              r_errctr <= '0;
      else if (w_err_hit && (r_errctr != '1)) r_errctr <= r_errctr + ERR_W'(1);
      if (CLR_i)                                        r_frmctr <= '0;
      else if ((r_state == ST_LOCK) && w_adv && w_v_wrap) r_frmctr <= r_frmctr + 8'd1;
    end
  end

  assign LOCK_o    = (r_state == ST_LOCK);
  assign ERR_o     = r_err;
  assign ERRCTRs_o = r_errctr;
  assign FRMCTRs_o = r_frmctr;

endmodule

// File: tb/tb_test_pattern_checker.sv
// tb/tb_test_pattern_checker.sv - self-checking bench for test_pattern_checker
module tb_test_pattern_checker;

  localparam int HT = 20;
  localparam int VT = 6;
  localparam int CL = 4;
  localparam int UT = 8;
  localparam int EW = 4;
  localparam int FRAME = HT * VT;

  logic          ck = 1'b0;
  logic          xar = 1'b0;
  logic          ckee = 1'b0;
  logic          clr = 1'b0;
  logic [7:0]    r = 8'd0, g = 8'd0, b = 8'd0;
  logic          lock, err;
  logic [EW-1:0] errctr;
  logic [7:0]    frmctr;
  logic [9:0]    hctr;
  logic [8:0]    vctr;

  test_pattern_checker #(
    .H_TOTAL(HT), .V_TOTAL(VT), .CONFIRM_LNS(CL), .UNLOCK_TH(UT), .ERR_W(EW)
  ) dut (
    .CK_i(ck), .XAR_i(xar), .CK_EE_i(ckee), .R_i(r), .G_i(g), .B_i(b), .CLR_i(clr),
    .LOCK_o(lock), .ERR_o(err), .ERRCTRs_o(errctr), .FRMCTRs_o(frmctr),
    .HCTRs_o(hctr), .VCTRs_o(vctr)
  );

  always #5 ck = ~ck;

  int n_vec = 0;
  int n_miss = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: position p counts samples since the frame-start sample (p=0).
  bit m_track, m_lock, m_err;
  int m_p, m_f0, m_cons, m_errctr, m_frm, m_prev_r, m_prev_b;

  task automatic m_reset();
    m_track = 0; m_lock = 0; m_err = 0;
    m_p = 0; m_f0 = 0; m_cons = 0; m_errctr = 0; m_frm = 0; m_prev_r = 0; m_prev_b = 0;
  endtask

  task automatic model_step(input bit en, input logic [7:0] rr, gg, bb, input bit cc);
    bit fs, miss;
    int hh, vv, ff;
    m_err = 0;
    if (en) begin
      fs = (rr == 0) && (bb == 0) && (m_prev_r == (HT - 1) % 256) && (m_prev_b == (VT - 1) % 256);
      if (!m_track) begin
        if (fs) begin
          m_track = 1; m_lock = 0; m_p = 1; m_f0 = gg;
        end
      end else begin
        hh = m_p % HT;
        vv = (m_p / HT) % VT;
        ff = (m_f0 + m_p / FRAME) % 256;
        miss = ({rr, gg, bb} != {8'(hh), 8'(vv + ff + hh), 8'(vv)});
        m_p++;
        if (!m_lock) begin
          if (miss) m_track = 0;
          else if (m_p == CL * HT) m_lock = 1;
        end else begin
          if (miss) begin
            m_err = 1;
            if (m_errctr < (1 << EW) - 1) m_errctr++;
            m_cons++;
            if (m_cons == UT) begin
              m_track = 0; m_lock = 0; m_cons = 0;
            end
          end else begin
            m_cons = 0;
          end
          if (m_p % FRAME == 0) m_frm = (m_frm + 1) % 256;
        end
      end
      m_prev_r = rr;
      m_prev_b = bb;
    end
    if (cc) begin
      m_errctr = 0;
      m_frm = 0;
    end
  endtask

  task automatic step(input bit en, input logic [7:0] rr, gg, bb, input bit cc);
    ckee = en; r = rr; g = gg; b = bb; clr = cc;
    model_step(en, rr, gg, bb, cc);
    @(posedge ck); #1;
    cmp("lock", int'(lock), int'(m_lock));
    cmp("err", int'(err), int'(m_err));
    cmp("errctr", int'(errctr), m_errctr);
    cmp("frmctr", int'(frmctr), m_frm);
    if (m_track) begin
      cmp("hctr", int'(hctr), m_p % HT);
      cmp("vctr", int'(vctr), (m_p / HT) % VT);
    end
  endtask

  task automatic do_reset();
    xar = 0; ckee = 1'($urandom_range(1)); clr = 0;
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    @(posedge ck); #1;
    xar = 1; ckee = 0;
    m_reset();
    cmp("rst_lock", int'(lock), 0);
    cmp("rst_err", int'(err), 0);
    cmp("rst_errctr", int'(errctr), 0);
    cmp("rst_frmctr", int'(frmctr), 0);
    cmp("rst_hctr", int'(hctr), 0);
    cmp("rst_vctr", int'(vctr), 0);
  endtask

  // Pattern source
  int gh, gv, gf;

  task automatic gen_reset();
    gh = 0; gv = 0; gf = 0;
  endtask

  task automatic gen_next(output logic [7:0] rr, gg, bb);
    rr = 8'(gh); gg = 8'(gv + gf + gh); bb = 8'(gv);
    gh++;
    if (gh == HT) begin
      gh = 0; gv++;
      if (gv == VT) begin
        gv = 0; gf = (gf + 1) % 256;
      end
    end
  endtask

  task automatic run(input int n, input int duty);
    logic [7:0] rr, gg, bb;
    int done;
    done = 0;
    while (done < n) begin
      if ($urandom_range(99) < duty) begin
        gen_next(rr, gg, bb);
        step(1, rr, gg, bb, 0);
        done++;
      end else begin
        step(0, 8'($urandom), 8'($urandom), 8'($urandom), 0);
      end
    end
  endtask

  task automatic run_until(input int hh, input int vv);
    logic [7:0] rr, gg, bb;
    while (!(gh == hh && gv == vv)) begin
      gen_next(rr, gg, bb);
      step(1, rr, gg, bb, 0);
    end
  endtask

  task automatic corrupt_g(input bit cc);
    logic [7:0] rr, gg, bb;
    gen_next(rr, gg, bb);
    step(1, rr, gg ^ 8'h01, bb, cc);
  endtask

  typedef struct {
    bit         en;
    logic [7:0] vr, vg, vb;
    bit         lk;
    bit         er;
    int         ectr;
    int         h;
    bit         chk_h;
  } vec_t;

  vec_t tbl[8];
  int   e0;

  initial begin
    tbl[0] = '{1'b0, 8'd0,  8'd0,  8'd0,  1'b0, 1'b0, 0, 0, 1'b1};
    tbl[1] = '{1'b1, 8'd19, 8'd3,  8'd5,  1'b0, 1'b0, 0, 0, 1'b1};
    tbl[2] = '{1'b1, 8'd0,  8'd7,  8'd0,  1'b0, 1'b0, 0, 1, 1'b1};
    tbl[3] = '{1'b0, 8'd55, 8'd55, 8'd55, 1'b0, 1'b0, 0, 1, 1'b1};
    tbl[4] = '{1'b1, 8'd1,  8'd8,  8'd0,  1'b0, 1'b0, 0, 2, 1'b1};
    tbl[5] = '{1'b1, 8'd2,  8'd9,  8'd0,  1'b0, 1'b0, 0, 3, 1'b1};
    tbl[6] = '{1'b1, 8'd3,  8'd99, 8'd0,  1'b0, 1'b0, 0, 0, 1'b0};
    tbl[7] = '{1'b1, 8'd0,  8'd0,  8'd0,  1'b0, 1'b0, 0, 0, 1'b0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      ckee = tbl[i].en; r = tbl[i].vr; g = tbl[i].vg; b = tbl[i].vb; clr = 0;
      @(posedge ck); #1;
      cmp($sformatf("tbl%0d_lock", i), int'(lock), int'(tbl[i].lk));
      cmp($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].er));
      cmp($sformatf("tbl%0d_errctr", i), int'(errctr), tbl[i].ectr);
      if (tbl[i].chk_h) cmp($sformatf("tbl%0d_hctr", i), int'(hctr), tbl[i].h);
    end

    // Clean stream: lock exactly after frame start + CL lines, two frames counted.
    do_reset();
    gen_reset();
    run(FRAME + CL * HT - 1, 100);
    cmp("s1_prelock", int'(lock), 0);
    run(1, 100);
    cmp("s1_lock", int'(lock), 1);
    run(3 * FRAME - FRAME - CL * HT, 100);
    cmp("s1_errctr", int'(errctr), 0);
    cmp("s1_frmctr", int'(frmctr), 2);

    // Single bit error while locked.
    run_until(10, 3);
    corrupt_g(0);
    cmp("s2_errpulse", int'(err), 1);
    run(3, 100);
    cmp("s2_errctr", int'(errctr), 1);
    cmp("s2_lock", int'(lock), 1);

    // Generator V-reset mid-frame: UT errors, unlock, relock on next frame start.
    run_until(15, 4);
    e0 = int'(errctr);
    gh = 0; gv = 0;
    run(UT, 100);
    cmp("s3_errctr", int'(errctr), e0 + UT);
    cmp("s3_unlock", int'(lock), 0);
    run(FRAME + CL * HT - UT, 100);
    cmp("s3_relock", int'(lock), 1);

    // Sparse sample enable gives the same outcome as the clean stream.
    do_reset();
    gen_reset();
    run(3 * FRAME, 33);
    cmp("s4_lock", int'(lock), 1);
    cmp("s4_errctr", int'(errctr), 0);
    cmp("s4_frmctr", int'(frmctr), 2);

    // Error counter saturation, then clear against a same-cycle miss.
    for (int i = 0; i < 20; i++) begin
      run(5, 100);
      corrupt_g(0);
    end
    cmp("s5_sat", int'(errctr), (1 << EW) - 1);
    corrupt_g(1);
    cmp("s5_clr_errctr", int'(errctr), 0);
    cmp("s5_clr_frmctr", int'(frmctr), 0);

    // Miss during CONFIRM falls back to SEARCH without counting; reset mid-lock.
    do_reset();
    gen_reset();
    run(FRAME + 3, 100);
    corrupt_g(0);
    cmp("s6_confirm_drop", int'(lock), 0);
    cmp("s6_errctr", int'(errctr), 0);
    run(2 * FRAME - (FRAME + 4) + CL * HT + 10, 100);
    cmp("s6_relock", int'(lock), 1);
    run(FRAME, 100);
    corrupt_g(0);
    do_reset();
    run(10, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
